pk_flash_store: RTL and testbench
=================================

// Module: pk_flash_store
// PURPOSE
//  Responder end of the Pass-Keeper flash interface: a 16-entry x 256-bit record store ({account, encrypted password}).
//  Accepts program requests (flash_write/add_flash/write_data_flash) from the top level.
//  Serves registered read data on data_flash and reports max_address for the boot-load scan.
//  Models flash timing: multi-cycle program, bulk erase, busy, data retention across rst.
// PARAMETERS
//  DATA_W        256  record width (bits)
//  ADDR_W        4    address width; depth = 2**ADDR_W = 16
//  PROG_CYCLES   4    cycles from accepted program to commit (>=1)
//  ERASE_CYCLES  8    cycles from accepted erase to completion (>=1)
// PORTS
//  clk               in   1    clock, rising edge
//  rst               in   1    asynchronous, active-low reset
//  flash_write       in   1    program request, sampled while busy=0
//  add_flash         in   4    program target / read address
//  write_data_flash  in   256  program data
//  erase_all         in   1    bulk-erase request, sampled while busy=0
//  data_flash        out  256  registered read data, 1-cycle latency
//  max_address       out  4    highest valid entry index (0 when empty)
//  empty             out  1    1 = no valid entries
//  busy              out  1    program or erase in progress
//  wr_err            out  1    1-cycle pulse: request dropped
// BEHAVIOUR
//  Reset values (rst=0): data_flash=0, busy=0, wr_err=0, FSM=IDLE, counter=0.
//  Retention: array and valid[15:0] are not reset. After power-up they are X until the first erase; max_address/empty follow valid.
//  States: IDLE, PROG, ERASE.
//   IDLE:  erase_all=1 -> ERASE, busy=1 next cycle.
//          else flash_write=1 -> latch addr/data, PROG, busy=1 next cycle.
//   PROG:  count PROG_CYCLES cycles; on the last cycle commit mem[addr], set valid[addr]; -> IDLE, busy=0 next cycle.
//   ERASE: count ERASE_CYCLES cycles; on the last cycle set all entries to all-ones and clear valid; -> IDLE.
//  Simultaneous flash_write & erase_all in IDLE: erase wins; wr_err pulses next cycle.
//  Request (flash_write or erase_all) while busy=1: ignored; wr_err pulses next cycle. The in-flight operation is unaffected.
//  Reads: data_flash <= mem[add_flash] every cycle, including while busy. Reads return committed contents only.
//   A read of the target in the commit cycle returns old data; the new data appears from the next read.
//  Commit is atomic. rst asserted mid-PROG/ERASE aborts with the array and valid unchanged.
//  max_address/empty: combinational from the valid register; they update the cycle after commit or erase.
//  Re-programming a valid entry overwrites it; valid stays 1.
// CONFIGURATION
//  PK_FLASH_NOR_PROG_EN defined: program commits mem[addr] & data (bits only clear; NOR semantics).
//   If the target is already valid and (old & data) != data, wr_err pulses at commit. The AND result is still stored.
//  Undefined: program commits data verbatim; no commit-time wr_err.
// TESTING
//  1. rst=0 -> busy=0, wr_err=0, data_flash=0. erase_all 1 cycle -> busy high 8 cycles, then empty=1, max_address=0, reads all-ones.
//  2. After erase: program addr 3 data A5..A5 -> busy 4 cycles, valid[3]=1, max_address=3, empty=0. Read addr 3 -> A5..A5 one cycle later.
//  3. Program addr 9 while busy with addr 3 -> wr_err 1-cycle pulse; addr 9 stays invalid; max_address=3.
//  4. flash_write & erase_all same cycle after programming 3 -> erase executes, wr_err pulses, empty=1.
//  5. Start program addr 5, drop rst on PROG cycle 2 -> after release busy=0, valid[5]=0, mem[5] unchanged.
//  6. NOR_EN: program addr 2 0F..0F then FF..FF -> mem[2]=0F..0F, wr_err at second commit. Macro off -> FF..FF, no wr_err.

Source files
------------

// File: rtl/pk_flash_store.sv
// Pass-Keeper flash responder: 16 x 256-bit record store with program/erase timing and retention.
// Optional: define PK_FLASH_NOR_PROG_EN for NOR program semantics (bits only clear).

module pk_flash_cell #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              erase,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q,
  output logic              vld
);
  // No reset: contents and valid survive rst like real flash cells.
  always_ff @(posedge clk) begin
    if (erase) begin
      q   <= '1;
      vld <= 1'b0;
    end else if (wr_en) begin
      q   <= wdata;
      vld <= 1'b1;
    end
  end
endmodule

module pk_flash_store #(
  parameter int DATA_W       = 256,
  parameter int ADDR_W       = 4,
  parameter int PROG_CYCLES  = 4,
  parameter int ERASE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash_write,
  input  logic [ADDR_W-1:0] add_flash,
  input  logic [DATA_W-1:0] write_data_flash,
  input  logic              erase_all,
  output logic [DATA_W-1:0] data_flash,
  output logic [ADDR_W-1:0] max_address,
  output logic              empty,
  output logic              busy,
  output logic              wr_err
);
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PROG, ERASE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } prog_req_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  prog_req_t                      req;
  logic [DEPTH-1:0][DATA_W-1:0]   cell_q;
  logic [DEPTH-1:0]               valid;
  logic [DATA_W-1:0]              commit_data;
  logic                           nor_err;
  logic                           prog_commit;
  logic                           erase_done;

  assign prog_commit = (state == PROG)  && (cnt == PROG_LAST);
  assign erase_done  = (state == ERASE) && (cnt == ERASE_LAST);

`ifdef PK_FLASH_NOR_PROG_EN
  logic [DATA_W-1:0] old_q;
  assign old_q       = cell_q[req.addr];
  assign commit_data = old_q & req.data;
  assign nor_err     = valid[req.addr] && ((old_q & req.data) != req.data);
`else
  assign commit_data = req.data;
  assign nor_err     = 1'b0;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    pk_flash_cell #(.DATA_W(DATA_W)) u_cell (
      .clk   (clk),
      .wr_en (prog_commit && (req.addr == ADDR_W'(g))),
      .erase (erase_done),
      .wdata (commit_data),
      .q     (cell_q[g]),
      .vld   (valid[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      wr_err <= 1'b0;
      req    <= '0;
    end else begin
      wr_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (erase_all) begin
            state  <= ERASE;
            busy   <= 1'b1;
            wr_err <= flash_write;
          end else if (flash_write) begin
            state    <= PROG;
            busy     <= 1'b1;
            req.addr <= add_flash;
            req.data <= write_data_flash;
          end
        end
        PROG: begin
          // Requests arriving while busy are dropped and flagged.
          wr_err <= flash_write | erase_all | (prog_commit & nor_err);
          if (prog_commit) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ERASE: begin
          wr_err <= flash_write | erase_all;
          if (erase_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Read port sees committed contents only; a same-cycle commit shows up one read later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_flash <= '0;
    else      data_flash <= cell_q[add_flash];
  end

  always_comb begin
    max_address = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i]) max_address = ADDR_W'(i);
  end

  assign empty = ~|valid;

endmodule

// File: tb/tb_pk_flash_store.sv
// Self-checking bench for pk_flash_store: directed table, corner sequences and randomized ops vs a transaction model.
module tb_pk_flash_store;
  localparam int PROG_CYCLES  = 4;
  localparam int ERASE_CYCLES = 8;

  logic         clk = 0;
  logic         rst = 0;
  logic         flash_write = 0;
  logic [3:0]   add_flash = 0;
  logic [255:0] write_data_flash = 0;
  logic         erase_all = 0;
  logic [255:0] data_flash;
  logic [3:0]   max_address;
  logic         empty, busy, wr_err;

  pk_flash_store #(.DATA_W(256), .ADDR_W(4), .PROG_CYCLES(PROG_CYCLES), .ERASE_CYCLES(ERASE_CYCLES)) dut (
    .clk(clk), .rst(rst), .flash_write(flash_write), .add_flash(add_flash),
    .write_data_flash(write_data_flash), .erase_all(erase_all), .data_flash(data_flash),
    .max_address(max_address), .empty(empty), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Committed contents as seen by a reader; updated once per completed operation.
  logic [255:0] mdl_mem [16];
  bit           mdl_val [16];
  bit           mdl_known = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [3:0] mdl_max();
    logic [3:0] m = 0;
    for (int i = 0; i < 16; i++) if (mdl_val[i]) m = 4'(i);
    return m;
  endfunction

  function automatic bit mdl_empty();
    for (int i = 0; i < 16; i++) if (mdl_val[i]) return 0;
    return 1;
  endfunction

  task automatic chk_status(input string nm);
    chk({nm, "_max"}, max_address, mdl_max());
    chk({nm, "_empty"}, empty, mdl_empty());
  endtask

  task automatic rd(input logic [3:0] a, input string nm);
    add_flash = a;
    @(posedge clk); #1;
    chk(nm, data_flash, mdl_mem[a]);
  endtask

  // One complete operation; optional dropped request injected in the first busy cycle.
  task automatic do_op(input bit is_erase, input bit also_wr, input logic [3:0] a,
                       input logic [255:0] d, input bit collide, input bit coll_wr,
                       input logic [3:0] coll_a, input string nm);
    logic [255:0] old;
    bit exp_err;
    int n;
    old = mdl_mem[a];
    flash_write = !is_erase || also_wr;
    erase_all = is_erase;
    add_flash = a;
    write_data_flash = d;
    @(posedge clk); #1;
    flash_write = 0; erase_all = 0;
    chk({nm, "_busy_start"}, busy, 1);
    chk({nm, "_wr_err_accept"}, wr_err, is_erase && also_wr);
    if (mdl_known) chk({nm, "_rd_first"}, data_flash, old);
    if (collide) begin
      flash_write = coll_wr; erase_all = !coll_wr;
      add_flash = coll_a; write_data_flash = rnd256();
    end
    n = 0;
    while (n < 64) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && collide) begin
        chk({nm, "_wr_err_busy"}, wr_err, 1);
        flash_write = 0; erase_all = 0; add_flash = a;
      end else begin
        if (busy) chk({nm, "_wr_err_quiet"}, wr_err, 0);
        if (mdl_known) chk({nm, "_rd_old"}, data_flash, old);
      end
      if (!busy) break;
    end
    chk({nm, "_busy_len"}, n, is_erase ? ERASE_CYCLES : PROG_CYCLES);
    exp_err = 0;
    if (is_erase) begin
      for (int i = 0; i < 16; i++) begin mdl_mem[i] = '1; mdl_val[i] = 0; end
      mdl_known = 1;
    end else begin
`ifdef PK_FLASH_NOR_PROG_EN
      exp_err = mdl_val[a] && ((mdl_mem[a] & d) != d);
      mdl_mem[a] = mdl_mem[a] & d;
`else
      mdl_mem[a] = d;
`endif
      mdl_val[a] = 1;
    end
    chk({nm, "_wr_err_commit"}, wr_err, exp_err);
    chk_status(nm);
    rd(a, {nm, "_rd_new"});
  endtask

  typedef struct {
    logic [3:0]   addr;
    logic [255:0] data;
    bit           coll;
    logic [3:0]   coll_addr;
    logic [3:0]   exp_max;
    bit           exp_empty;
  } vec_t;

  vec_t tbl [6];
  logic [255:0] pat_a5, pat_0f, pat_ff, exp6;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_0f = {32{8'h0F}};
    pat_ff = {32{8'hFF}};
    tbl[0] = '{4'd3,  pat_a5,   1, 4'd9,  4'd3,  0};
    tbl[1] = '{4'd1,  rnd256(), 0, 4'd0,  4'd3,  0};
    tbl[2] = '{4'd12, rnd256(), 1, 4'd15, 4'd12, 0};
    tbl[3] = '{4'd0,  rnd256(), 0, 4'd0,  4'd12, 0};
    tbl[4] = '{4'd15, rnd256(), 0, 4'd0,  4'd15, 0};
    tbl[5] = '{4'd12, rnd256(), 0, 4'd0,  4'd15, 0};
    for (int i = 0; i < 16; i++) begin mdl_mem[i] = '0; mdl_val[i] = 0; end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_data", data_flash, 0);
    rst = 1;
    @(posedge clk); #1;

    // Initial erase
    do_op(1, 0, 4'd6, '0, 0, 0, 0, "erase0");
    chk("erase0_empty_c", empty, 1);
    chk("erase0_max_c", max_address, 0);
    rd(4'd3, "erase0_rd3");

    // Directed program table
    for (int i = 0; i < 6; i++) begin
      do_op(0, 0, tbl[i].addr, tbl[i].data, tbl[i].coll, 1, tbl[i].coll_addr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_max_c", i), max_address, tbl[i].exp_max);
      chk($sformatf("tbl%0d_empty_c", i), empty, tbl[i].exp_empty);
    end
`ifndef PK_FLASH_NOR_PROG_EN
    add_flash = 4'd3; @(posedge clk); #1;
    chk("tbl_rd3_a5", data_flash, pat_a5);
`endif

    // Simultaneous write and erase: erase wins and the write is flagged
    do_op(1, 1, 4'd3, rnd256(), 0, 0, 0, "wr_erase");
    chk("wr_erase_empty_c", empty, 1);

    // Reset mid-program aborts with array untouched
    do_op(0, 0, 4'd3, rnd256(), 0, 0, 0, "pre5");
    flash_write = 1; add_flash = 4'd5; write_data_flash = rnd256();
    @(posedge clk); #1;
    flash_write = 0;
    chk("abort_busy_start", busy, 1);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_err", wr_err, 0);
    chk("abort_data", data_flash, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("abort_busy_after", busy, 0);
    chk("abort_max_c", max_address, 4'd3);
    chk_status("abort");
    rd(4'd5, "abort_rd5");

    // Program over a valid entry
    do_op(0, 0, 4'd2, pat_0f, 0, 0, 0, "nor1");
    do_op(0, 0, 4'd2, pat_ff, 0, 0, 0, "nor2");
`ifdef PK_FLASH_NOR_PROG_EN
    exp6 = pat_0f;
`else
    exp6 = pat_ff;
`endif
    add_flash = 4'd2; @(posedge clk); #1;
    chk("nor_rd2", data_flash, exp6);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      do_op(r == 0, (r == 0) && $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rnd256(),
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            $sformatf("rnd%0d", k));
      rd(4'($urandom_range(0, 15)), $sformatf("rnd%0d_rdx", k));
    end
    for (int i = 0; i < 16; i++) rd(4'(i), $sformatf("final_rd%0d", i));
    chk_status("final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
